// File: rtl/ub_burst_buffer_if.sv
// ============================================================================
// Module   : ub_burst_buffer_if
// Purpose  : Bundles the DMA command / write-beat / read-beat handshakes,
//            status outputs and the per-bank PE ports of ub_burst_buffer.
// Ports    : cmd_*   - DMA burst command (valid/ready, direction, addr, len)
//            wr_*    - DRAM->UB write beats (valid/ready/data)
//            rd_*    - UB->DRAM read beats (valid/ready/data)
//            busy, xfer_done, stall_cnt - status
//            pe_*    - per-bank PE read/write ports (packed NB-wide)
// Modports : slave  - buffer side
//            master - DMA engine / PE array side
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ub_burst_buffer_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int NB      = 4,
    parameter int LEN_W   = 8,
    parameter int GADDR_W = ADDR_W + $clog2(NB)
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [GADDR_W-1:0]   cmd_addr;
    logic [LEN_W-1:0]     cmd_len;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [DATA_W-1:0]    wr_data;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [DATA_W-1:0]    rd_data;
    logic                 busy;
    logic                 xfer_done;
    logic [15:0]          stall_cnt;
    logic [NB-1:0]        pe_read_en;
    logic [NB-1:0]        pe_write_en;
    logic [NB*ADDR_W-1:0] pe_addr;
    logic [NB*DATA_W-1:0] pe_data_in;
    logic [NB*DATA_W-1:0] pe_data_out;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data, rd_ready,
        input  pe_read_en, pe_write_en, pe_addr, pe_data_in,
        output cmd_ready, wr_ready, rd_valid, rd_data,
        output busy, xfer_done, stall_cnt, pe_data_out
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data, rd_ready,
        output pe_read_en, pe_write_en, pe_addr, pe_data_in,
        input  cmd_ready, wr_ready, rd_valid, rd_data,
        input  busy, xfer_done, stall_cnt, pe_data_out
    );
endinterface

`default_nettype wire

// File: rtl/ub_burst_buffer.sv
// ============================================================================
// Module   : ub_burst_buffer
// Purpose  : NB-bank SRAM unified buffer. A burst DMA port streams beats
//            between DRAM and the banks; each bank also has a PE port with
//            priority. A DMA beat whose bank is in use by its PE stalls.
// Ports    : clk   - rising-edge clock
//            reset - asynchronous active-low reset
//            bus   - ub_burst_buffer_if.slave (DMA, status and PE signals)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ub_burst_buffer #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int NB         = 4,
    parameter int BANK_BITS  = $clog2(NB),
    parameter int GADDR_W    = ADDR_W + BANK_BITS,
    parameter int INTERLEAVE = 1,
    parameter int LEN_W      = 8
) (
    input wire               clk,
    input wire               reset,
    ub_burst_buffer_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WR    = 2'd1,
        S_RD    = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                         r_state;
    logic [GADDR_W-1:0]             r_ptr;
    logic [LEN_W-1:0]               r_cnt;
    logic                           r_xfer_done;
    logic [15:0]                    r_stall;
    logic                           r_inflight;
    logic [BANK_BITS-1:0]           r_rd_bank;
    logic [DATA_W-1:0]              r_fifo [2];
    logic                           r_wptr;
    logic                           r_rptr;
    logic [1:0]                     r_occ;

    logic [BANK_BITS-1:0]           w_bank;
    logic [ADDR_W-1:0]              w_local;
    logic [NB-1:0]                  w_pe_busy;
    logic                           w_conflict;
    logic                           w_wr_fire;
    logic                           w_rd_issue;
    logic                           w_pop;
    logic                           w_stall;
    logic [1:0]                     w_credit;
    logic [NB-1:0][DATA_W-1:0]      w_dma_q;

    // Global pointer -> (bank, local word) mapping
    if (INTERLEAVE != 0) begin : g_interleave
        assign w_bank  = r_ptr[BANK_BITS-1:0];
        assign w_local = r_ptr[GADDR_W-1:BANK_BITS];
    end else begin : g_linear
        assign w_bank  = r_ptr[GADDR_W-1 -: BANK_BITS];
        assign w_local = r_ptr[ADDR_W-1:0];
    end

    assign w_pe_busy  = bus.pe_read_en | bus.pe_write_en;
    assign w_conflict = w_pe_busy[w_bank];

    // Skid occupancy plus the read still in the SRAM pipeline must leave a
    // free slot, so an issued read always has somewhere to land.
    assign w_credit   = r_occ + {1'b0, r_inflight};
    assign w_wr_fire  = (r_state == S_WR) && bus.wr_valid && !w_conflict;
    assign w_rd_issue = (r_state == S_RD) && !w_conflict && (w_credit < 2'd2);
    assign w_pop      = (r_occ != 2'd0) && bus.rd_ready;
    assign w_stall    = ((r_state == S_WR) && bus.wr_valid && w_conflict) ||
                        ((r_state == S_RD) && w_conflict);

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.wr_ready  = (r_state == S_WR) && !w_conflict;
    assign bus.rd_valid  = (r_occ != 2'd0);
    assign bus.rd_data   = r_fifo[r_rptr];
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.xfer_done = r_xfer_done;
    assign bus.stall_cnt = r_stall;

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic [DATA_W-1:0] r_pe_q;
        logic [DATA_W-1:0] r_dma_q;
        logic [ADDR_W-1:0] w_pe_addr;
        logic              w_sel;

        assign w_pe_addr = bus.pe_addr[b*ADDR_W +: ADDR_W];
        assign w_sel     = (w_bank == BANK_BITS'(b));

        // PE and DMA writes are mutually exclusive: any PE activity on this
        // bank blocks the DMA beat.
        always_ff @(posedge clk) begin
            if (bus.pe_write_en[b]) begin
                r_mem[w_pe_addr] <= bus.pe_data_in[b*DATA_W +: DATA_W];
            end else if (w_wr_fire && w_sel) begin
                r_mem[w_local] <= bus.wr_data;
            end
        end

        // Read-first: a same-cycle PE write is seen by the next read only.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_pe_q  <= '0;
                r_dma_q <= '0;
            end else begin
                if (bus.pe_read_en[b]) begin
                    r_pe_q <= r_mem[w_pe_addr];
                end
                if (w_rd_issue && w_sel) begin
                    r_dma_q <= r_mem[w_local];
                end
            end
        end

        assign bus.pe_data_out[b*DATA_W +: DATA_W] = r_pe_q;
        assign w_dma_q[b] = r_dma_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_xfer_done <= 1'b0;
            r_stall     <= '0;
            r_inflight  <= 1'b0;
            r_rd_bank   <= '0;
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_occ       <= '0;
        end else begin
            r_xfer_done <= 1'b0;

            if (w_stall && (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 16'd1;
            end

            // SRAM read returns one cycle after issue, then enters the skid FIFO
            r_inflight <= w_rd_issue;
            if (w_rd_issue) begin
                r_rd_bank <= w_bank;
            end
            if (r_inflight) begin
                r_fifo[r_wptr] <= w_dma_q[r_rd_bank];
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({r_inflight, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_ptr <= bus.cmd_addr;
                        r_cnt <= bus.cmd_len;
                        if (bus.cmd_len == '0) begin
                            r_xfer_done <= 1'b1;
                        end else if (bus.cmd_write) begin
                            r_state <= S_WR;
                        end else begin
                            r_state <= S_RD;
                        end
                    end
                end
                S_WR: begin
                    if (w_wr_fire) begin
                        r_ptr <= r_ptr + GADDR_W'(1);
                        r_cnt <= r_cnt - LEN_W'(1);
                        if (r_cnt == LEN_W'(1)) begin
                            r_state     <= S_IDLE;
                            r_xfer_done <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    if (w_rd_issue) begin
                        r_ptr <= r_ptr + GADDR_W'(1);
                        r_cnt <= r_cnt - LEN_W'(1);
                        if (r_cnt == LEN_W'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if ((r_occ == 2'd0) && !r_inflight) begin
                        r_state     <= S_IDLE;
                        r_xfer_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ub_burst_buffer.sv
// ============================================================================
// Module   : tb_ub_burst_buffer
// Purpose  : Directed self-checking bench for ub_burst_buffer: reset values,
//            write/read bursts, rd_ready back-pressure, PE conflict stalls,
//            address wrap, zero-length command and reset mid-burst.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ub_burst_buffer;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 10;
    localparam int NB      = 4;
    localparam int LEN_W   = 8;
    localparam int GADDR_W = 12;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [DATA_W-1:0] got_q [$];

    ub_burst_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NB(NB),
                         .LEN_W(LEN_W), .GADDR_W(GADDR_W)) bus ();

    ub_burst_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NB(NB),
                      .INTERLEAVE(1), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pe_read(input int b, input logic [ADDR_W-1:0] a,
                           output logic [DATA_W-1:0] d);
        bus.pe_read_en = '0;
        bus.pe_read_en[b] = 1'b1;
        bus.pe_addr[b*ADDR_W +: ADDR_W] = a;
        tick();
        bus.pe_read_en = '0;
        d = bus.pe_data_out[b*DATA_W +: DATA_W];
    endtask

    // Write burst with wr_valid held high; optional PE write on pe_bank for
    // the first pe_cycles cycles of the burst.
    task automatic run_wr(input logic [GADDR_W-1:0] addr, input int len,
                          input logic [DATA_W-1:0] base, input int pe_bank,
                          input int pe_cycles, output int beats, output int lo);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_len   = LEN_W'(len);
        bus.wr_valid  = 1'b1;
        bus.wr_data   = base;
        tick();
        bus.cmd_valid = 1'b0;
        beats = 0;
        lo    = 0;
        for (int c = 0; c < 64 && beats < len; c++) begin
            if (pe_bank >= 0) bus.pe_write_en[pe_bank] = (c < pe_cycles);
            bus.wr_data = base + DATA_W'(beats);
            #1;
            if (bus.wr_ready) beats++;
            else lo++;
            tick();
        end
        bus.wr_valid    = 1'b0;
        bus.pe_write_en = '0;
    endtask

    // Read burst; mode 0: rd_ready always 1, mode 1: rd_ready = 1,0,0,1,0,0...
    task automatic run_rd(input logic [GADDR_W-1:0] addr, input int len,
                          input int mode, output int first_v, output bit done,
                          output logic busy_at_done);
        got_q.delete();
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = addr;
        bus.cmd_len   = LEN_W'(len);
        tick();
        bus.cmd_valid = 1'b0;
        first_v = -1;
        done = 1'b0;
        busy_at_done = 1'bx;
        for (int c = 0; c < 200 && !done; c++) begin
            bus.rd_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            #1;
            if (bus.xfer_done) begin
                done = 1'b1;
                busy_at_done = bus.busy;
            end
            if (bus.rd_valid && first_v < 0) first_v = c;
            if (bus.rd_valid && bus.rd_ready) got_q.push_back(bus.rd_data);
            tick();
        end
        bus.rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_tests++;
        if (bus.busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.xfer_done !== 1'b0 ||
            bus.wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags busy=%b rd_valid=%b xfer_done=%b wr_ready=%b expected all 0",
                     bus.busy, bus.rd_valid, bus.xfer_done, bus.wr_ready);
        end
        n_tests++;
        if (bus.stall_cnt !== 16'd0 || bus.rd_data !== '0 || bus.pe_data_out !== '0) begin
            n_fail++;
            $display("FAIL reset_data stall_cnt=%h rd_data=%h pe_data_out=%h expected 0",
                     bus.stall_cnt, bus.rd_data, bus.pe_data_out);
        end
        reset = 1'b1;
        tick();
        n_tests++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cmd_ready got=%b expected 1", bus.cmd_ready);
        end
    endtask

    task automatic test_write_burst();
        int beats, lo;
        logic [DATA_W-1:0] d;
        run_wr(12'h000, 8, 32'hA000, -1, 0, beats, lo);
        n_tests++;
        if (beats !== 8 || lo !== 0) begin
            n_fail++;
            $display("FAIL wr_beats beats=%0d ready_low=%0d expected 8 and 0", beats, lo);
        end
        n_tests++;
        if (bus.xfer_done !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done xfer_done=%b busy=%b expected 1 and 0", bus.xfer_done, bus.busy);
        end
        tick();
        n_tests++;
        if (bus.xfer_done !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done_pulse got=%b expected 0", bus.xfer_done);
        end
        for (int i = 0; i < 8; i++) begin
            pe_read(i % 4, ADDR_W'(i / 4), d);
            n_tests++;
            if (d !== 32'hA000 + i) begin
                n_fail++;
                $display("FAIL wr_mem[%0d] got=%h expected=%h", i, d, 32'hA000 + i);
            end
        end
    endtask

    task automatic test_read_burst(input int mode);
        int first_v;
        bit done;
        logic busy_d;
        run_rd(12'h000, 8, mode, first_v, done, busy_d);
        n_tests++;
        if (first_v !== 2) begin
            n_fail++;
            $display("FAIL rd_latency mode=%0d got=%0d expected 2", mode, first_v);
        end
        n_tests++;
        if (got_q.size() !== 8) begin
            n_fail++;
            $display("FAIL rd_count mode=%0d got=%0d expected 8", mode, got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            n_tests++;
            if (got_q[i] !== 32'hA000 + i) begin
                n_fail++;
                $display("FAIL rd_data[%0d] mode=%0d got=%h expected=%h",
                         i, mode, got_q[i], 32'hA000 + i);
            end
        end
        n_tests++;
        if (done !== 1'b1 || busy_d !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_done mode=%0d done=%b busy=%b expected 1 and 0", mode, done, busy_d);
        end
    endtask

    task automatic test_conflict();
        int beats, lo;
        logic [DATA_W-1:0] d;
        bus.pe_addr[1*ADDR_W +: ADDR_W]    = 10'h200;
        bus.pe_data_in[1*DATA_W +: DATA_W] = 32'h5A5A5A5A;
        // gaddr 0x041 -> bank 1 local 0x10, so the first beat hits bank 1
        run_wr(12'h041, 4, 32'hB000, 1, 3, beats, lo);
        n_tests++;
        if (beats !== 4 || lo !== 3) begin
            n_fail++;
            $display("FAIL cf_beats beats=%0d ready_low=%0d expected 4 and 3", beats, lo);
        end
        n_tests++;
        if (bus.stall_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL cf_stall got=%0d expected 3", bus.stall_cnt);
        end
        n_tests++;
        if (bus.xfer_done !== 1'b1) begin
            n_fail++;
            $display("FAIL cf_done got=%b expected 1", bus.xfer_done);
        end
        pe_read(1, 10'h200, d);
        n_tests++;
        if (d !== 32'h5A5A5A5A) begin
            n_fail++;
            $display("FAIL cf_pe_data got=%h expected 5a5a5a5a", d);
        end
        pe_read(1, 10'h010, d);
        n_tests++;
        if (d !== 32'hB000) begin
            n_fail++;
            $display("FAIL cf_first_beat got=%h expected 0000b000", d);
        end
        pe_read(0, 10'h011, d);
        n_tests++;
        if (d !== 32'hB003) begin
            n_fail++;
            $display("FAIL cf_last_beat got=%h expected 0000b003", d);
        end
    endtask

    task automatic test_wrap_and_zero();
        int beats, lo;
        logic [DATA_W-1:0] d;
        int bk  [4] = '{2, 3, 0, 1};
        int loc [4] = '{10'h3FF, 10'h3FF, 0, 0};
        run_wr(12'hFFE, 4, 32'hC000, -1, 0, beats, lo);
        n_tests++;
        if (beats !== 4) begin
            n_fail++;
            $display("FAIL wrap_beats got=%0d expected 4", beats);
        end
        for (int i = 0; i < 4; i++) begin
            pe_read(bk[i], ADDR_W'(loc[i]), d);
            n_tests++;
            if (d !== 32'hC000 + i) begin
                n_fail++;
                $display("FAIL wrap_mem[%0d] got=%h expected=%h", i, d, 32'hC000 + i);
            end
        end
        // zero-length command to gaddr 5 with a write beat offered
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 12'h005;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b1;
        bus.wr_data   = 32'hDEAD;
        tick();
        bus.cmd_valid = 1'b0;
        n_tests++;
        if (bus.xfer_done !== 1'b1 || bus.busy !== 1'b0 || bus.wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len xfer_done=%b busy=%b wr_ready=%b expected 1,0,0",
                     bus.xfer_done, bus.busy, bus.wr_ready);
        end
        tick();
        bus.wr_valid = 1'b0;
        n_tests++;
        if (bus.xfer_done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_pulse got=%b expected 0", bus.xfer_done);
        end
        pe_read(1, 10'h001, d);
        n_tests++;
        if (d !== 32'hA005) begin
            n_fail++;
            $display("FAIL zero_len_mem got=%h expected 0000a005", d);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [DATA_W-1:0] exp_v [3] = '{32'hC002, 32'hC003, 32'hA002};
        logic [DATA_W-1:0] d;
        int beats = 0;
        got_q.delete();
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 12'h000;
        bus.cmd_len   = 8'd8;
        tick();
        bus.cmd_valid = 1'b0;
        for (int c = 0; c < 100 && beats < 3; c++) begin
            bus.rd_ready = 1'b1;
            #1;
            if (bus.rd_valid) begin
                got_q.push_back(bus.rd_data);
                beats++;
            end
            tick();
        end
        bus.rd_ready = 1'b0;
        n_tests++;
        if (got_q.size() !== 3) begin
            n_fail++;
            $display("FAIL rst_pre_count got=%0d expected 3", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            n_tests++;
            if (got_q[i] !== exp_v[i]) begin
                n_fail++;
                $display("FAIL rst_pre_data[%0d] got=%h expected=%h", i, got_q[i], exp_v[i]);
            end
        end
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_busy got=%b expected 1", bus.busy);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== '0) begin
            n_fail++;
            $display("FAIL rst_async busy=%b rd_valid=%b rd_data=%h expected 0",
                     bus.busy, bus.rd_valid, bus.rd_data);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        n_tests++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.xfer_done !== 1'b0 ||
            bus.stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_release cmd_ready=%b busy=%b xfer_done=%b stall=%0d expected 1,0,0,0",
                     bus.cmd_ready, bus.busy, bus.xfer_done, bus.stall_cnt);
        end
        pe_read(2, 10'h001, d);
        n_tests++;
        if (d !== 32'hA006) begin
            n_fail++;
            $display("FAIL rst_mem_keep got=%h expected 0000a006", d);
        end
        pe_read(1, 10'h200, d);
        n_tests++;
        if (d !== 32'h5A5A5A5A) begin
            n_fail++;
            $display("FAIL rst_pe_keep got=%h expected 5a5a5a5a", d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        reset            = 1'b0;
        bus.cmd_valid    = 1'b0;
        bus.cmd_write    = 1'b0;
        bus.cmd_addr     = '0;
        bus.cmd_len      = '0;
        bus.wr_valid     = 1'b0;
        bus.wr_data      = '0;
        bus.rd_ready     = 1'b0;
        bus.pe_read_en   = '0;
        bus.pe_write_en  = '0;
        bus.pe_addr      = '0;
        bus.pe_data_in   = '0;

        test_reset();
        test_write_burst();
        test_read_burst(0);
        test_read_burst(1);
        test_conflict();
        test_wrap_and_zero();
        test_reset_mid_burst();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ub_burst_buffer.md
Name: ub_burst_buffer

Overview:
Parametrised successor to the single-word unified buffer. NB-bank SRAM buffer with a burst DMA port and per-bank PE ports. A DMA command (address, length, direction) streams beats over valid/ready handshakes. PE accesses have priority per bank; a conflicting DMA beat stalls. Sits between the DRAM DMA engine and the systolic PE array.

Parameters:
DATA_W, 32, word width
ADDR_W, 10, local address width per bank
NB, 4, number of banks (power of two, >=2)
BANK_BITS, $clog2(NB), bank-select bits
GADDR_W, ADDR_W+BANK_BITS, global address width
INTERLEAVE, 1, 1: bank=gaddr[BANK_BITS-1:0], local=gaddr>>BANK_BITS; 0: bank=gaddr[GADDR_W-1 -: BANK_BITS], local=gaddr[ADDR_W-1:0]
LEN_W, 8, burst length field width (beats)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  DMA command valid
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1=DRAM->UB, 0=UB->DRAM
cmd_addr  in  GADDR_W  global start address
cmd_len  in  LEN_W  beat count; 0 = no-op
wr_valid  in  1  write beat valid
wr_ready  out  1  write beat accepted this cycle
wr_data  in  DATA_W  write beat data
rd_valid  out  1  read beat valid
rd_ready  in  1  downstream accepts read beat
rd_data  out  DATA_W  read beat data
busy  out  1  high whenever state != IDLE
xfer_done  out  1  one-cycle pulse at burst completion
stall_cnt  out  16  saturating count of DMA conflict-stall cycles
pe_read_en  in  NB  per-bank PE read
pe_write_en  in  NB  per-bank PE write
pe_addr  in  NB*ADDR_W  per-bank local address
pe_data_in  in  NB*DATA_W  per-bank write data
pe_data_out  out  NB*DATA_W  per-bank read data, registered

Behaviour:
- Reset (reset=0, async): state IDLE; cmd_ready=1 after release; wr_ready, rd_valid, busy, xfer_done=0; rd_data, pe_data_out, stall_cnt=0; skid FIFO empty. SRAM contents not reset. Reset mid-burst aborts it; no xfer_done.
- FSM: IDLE -> WR_BURST (cmd_valid & cmd_write & len!=0), RD_BURST (cmd_valid & !cmd_write & len!=0). len==0: stay in IDLE, xfer_done pulses next cycle.
- Command captured on cmd_valid&cmd_ready: beat counter = cmd_len, pointer = cmd_addr. Each beat increments the pointer modulo 2^GADDR_W (wraps to 0).
- Conflict: DMA beat targets bank b while pe_read_en[b]|pe_write_en[b] -> PE access performed, DMA beat not issued, stall_cnt+1 (saturates at 16'hFFFF).
- WR_BURST: wr_ready = !conflict for current pointer bank. Beat commits on wr_valid&wr_ready, then counter-1. On last commit -> IDLE, xfer_done high the following cycle.
- RD_BURST: read issued when no conflict and (skid occupancy + in-flight) < 2. SRAM latency 1 cycle into a 2-entry skid FIFO; rd_valid = FIFO non-empty; rd_data = head. Last issue -> RD_DRAIN. RD_DRAIN -> IDLE when FIFO empty and nothing in flight; xfer_done pulses the next cycle. No beat lost or duplicated under any rd_ready pattern.
- PE port: read latency 1; pe_data_out[b] holds its value until the next PE read of bank b. Simultaneous read+write on the same bank is read-first (returns old data). PE writes never stall.
- A DMA read and a PE write to the same word never coincide, because a conflict blocks the DMA read.
- In IDLE the DMA holds no SRAM access; cmd_ready=0 in all other states.

Test Plan:
- Reset, INTERLEAVE=1: write burst addr 0, len 8, data 0xA000+i, wr_valid held high -> 8 consecutive wr_ready beats; xfer_done 1 cycle after beat 7; bank i%4, local i/4 holds 0xA000+i.
- Read burst addr 0, len 8, rd_ready always 1 -> rd_data 0xA000..0xA007 in order, first rd_valid 2 cycles after cmd accept, xfer_done after drain.
- Same read with rd_ready toggling 1,0,0,1... -> identical sequence, no loss or duplication, FIFO never exceeds 2.
- Write burst to bank 1 while pe_write_en[1] is held 3 cycles -> wr_ready low 3 cycles on bank-1 beats, stall_cnt=3, PE data at 0x200 intact.
- Write burst addr 0xFFE, len 4 -> beats land at 0xFFE, 0xFFF, 0x000, 0x001; len=0 command -> xfer_done only, no SRAM write.
- Assert reset mid read burst (beat 3 of 8) -> busy, rd_valid drop immediately; cmd_ready=1 after release; earlier SRAM writes preserved.
